shift_issue_stage: RTL and testbench
====================================

Name: shift_issue_stage

Overview:
Sequential front/back stage wrapped around the right-only barrel shifter in the execute path. Accepts RISC-V shift operations (SLL/SRL/SRA) over a valid/ready handshake and buffers them in a 2-entry FIFO. Left shifts are mapped onto the right shifter by bit reversal. The shifter's output is captured into a registered result port with its own valid/ready handshake.

Parameters:
width, 32, data width; must be a power of two, at least 2
tag_width, 4, width of the opaque tag carried alongside each operation

Ports:
CLK  input  1  clock; all state updates on the rising edge
RST  input  1  reset, synchronous, active-high
IN_VALID  input  1  upstream operation valid
IN_READY  output  1  stage can accept an operation this cycle
IN_FUNCT  input  2  00 SLL, 01 SRL, 11 SRA, 10 reserved
IN_W  input  $clog2(width)  shift amount
IN_A  input  width  operand
IN_TAG  input  tag_width  tag, returned unchanged
SH_OP  output  1  to shifter: 1 = arithmetic (sign fill), 0 = logical
SH_W  output  $clog2(width)  to shifter: shift amount
SH_A  output  width  to shifter: operand
SH_Y  input  width  from shifter: combinational result for SH_OP/SH_W/SH_A
OUT_VALID  output  1  result valid
OUT_READY  input  1  downstream accepts the result
OUT_Y  output  width  shifted result
OUT_TAG  output  tag_width  tag of the result
OUT_ERR  output  1  1 = reserved funct; OUT_Y then equals IN_A unchanged

Behaviour:
- Reset (RST=1 at an edge):
  - FIFO emptied; OUT_VALID=0, OUT_Y=0, OUT_TAG=0, OUT_ERR=0.
  - IN_READY=0 while RST=1.
  - Reset mid-operation discards all buffered and pending results. No partial output.
- Input handshake:
  - IN_READY = ~RST & ~fifo_full.
  - Push on IN_VALID & IN_READY.
  - No push-through while full, even if a pop happens in the same cycle.
  - IN_* are ignored when IN_VALID=0.
- FIFO:
  - 2 entries, wrap-around read/write pointers plus a count.
  - Simultaneous push and pop keeps the count unchanged.
  - Order is strictly preserved.
- Shifter drive (combinational from the FIFO head):
  - Head SLL: SH_OP=0, SH_A=bitreverse(A), SH_W=W.
  - Head SRL: SH_OP=0, SH_A=A, SH_W=W.
  - Head SRA: SH_OP=1, SH_A=A, SH_W=W.
  - Head reserved: SH_OP=0, SH_A=A, SH_W=0.
  - FIFO empty: SH_OP=0, SH_W=0, SH_A=0.
- Result register:
  - The head pops when the FIFO is non-empty and (OUT_VALID=0 or OUT_READY=1).
  - On pop: OUT_Y = bitreverse(SH_Y) for SLL, SH_Y for SRL/SRA, A for reserved.
  - On pop: OUT_TAG = tag; OUT_ERR = (funct==10); OUT_VALID=1.
  - OUT_VALID=1 and OUT_READY=1 with no pop: OUT_VALID becomes 0, and OUT_Y/OUT_TAG/OUT_ERR hold their last values.
  - OUT_VALID=1 and OUT_READY=0: all OUT_* are held stable.
- Latency and throughput:
  - An operation accepted at edge N appears with OUT_VALID=1 after edge N+1, when the result register is free.
  - Sustained throughput is 1 operation/cycle with OUT_READY held at 1.
- Back-pressure:
  - With OUT_READY=0, the stage absorbs 3 operations (2 FIFO + 1 result); IN_READY then drops.
  - It recovers 1 entry per cycle once OUT_READY=1.
- Shift amount W=0 returns A for all funct values.

Test Plan:
- Reset: hold RST=1 for 2 cycles with IN_VALID=1 -> IN_READY=0, OUT_VALID=0, OUT_Y=0; release -> IN_READY=1 next cycle.
- Functional, width=32, OUT_READY=1, one op per cycle:
  - SLL A=0x0000_00F1, W=4 -> 0x0000_0F10.
  - SRL A=0x8000_0000, W=31 -> 0x0000_0001.
  - SRA A=0x8000_0000, W=31 -> 0xFFFF_FFFF.
  - SRA A=0x7FFF_FFF0, W=4 -> 0x07FF_FFFF.
  - Tags 1..4 return in order; each result is valid 2 edges after acceptance.
- Reserved: funct=10, A=0x1234_5678, W=7 -> OUT_Y=0x1234_5678, OUT_ERR=1; the next SRL op shows OUT_ERR=0.
- Back-pressure: OUT_READY=0, offer 4 ops -> 3 accepted, IN_READY=0 on the 4th. OUT_* stay stable for 5 cycles. Then OUT_READY=1 -> 3 results drain on consecutive cycles, in order, and the 4th op is accepted.
- Reset mid-operation: 2 ops buffered and OUT_VALID=1, assert RST for 1 cycle -> OUT_VALID=0. No stale results emerge afterwards; a new op's result appears 2 edges after acceptance.
- Random: 10k ops with random IN_VALID/OUT_READY and random funct/W/A, checked against a reference model of <<, >>, >>> on 32 bits plus tag order -> zero mismatches, no lost or duplicated ops.

Source files
------------

// File: rtl/shift_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : shift_issue_stage
// Function : 2-entry issue FIFO and registered result stage wrapped around an
//            external right-only barrel shifter (SLL/SRL/SRA, tagged ops).
// Revision : 1.0 - initial release
// ============================================================================
module shift_issue_stage #(
    parameter int WIDTH     = 32,
    parameter int TAG_WIDTH = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     IN_VALID,
    output logic                     IN_READY,
    input  logic [1:0]               IN_FUNCT,
    input  logic [$clog2(WIDTH)-1:0] IN_W,
    input  logic [WIDTH-1:0]         IN_A,
    input  logic [TAG_WIDTH-1:0]     IN_TAG,
    output logic                     SH_OP,
    output logic [$clog2(WIDTH)-1:0] SH_W,
    output logic [WIDTH-1:0]         SH_A,
    input  logic [WIDTH-1:0]         SH_Y,
    output logic                     OUT_VALID,
    input  logic                     OUT_READY,
    output logic [WIDTH-1:0]         OUT_Y,
    output logic [TAG_WIDTH-1:0]     OUT_TAG,
    output logic                     OUT_ERR
);

    localparam int unsigned c_wbits = $clog2(WIDTH);

    localparam logic [1:0] c_sll = 2'b00;
    localparam logic [1:0] c_srl = 2'b01;
    localparam logic [1:0] c_rsv = 2'b10;
    localparam logic [1:0] c_sra = 2'b11;

    // FIFO storage and bookkeeping
    logic [1:0]           r_funct [2];
    logic [c_wbits-1:0]   r_w     [2];
    logic [WIDTH-1:0]     r_a     [2];
    logic [TAG_WIDTH-1:0] r_tag   [2];
    logic                 r_wptr;
    logic                 r_rptr;
    logic [1:0]           r_count;

    // Result register
    logic                 r_out_valid;
    logic [WIDTH-1:0]     r_out_y;
    logic [TAG_WIDTH-1:0] r_out_tag;
    logic                 r_out_err;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic [1:0]           w_head_funct;
    logic [c_wbits-1:0]   w_head_w;
    logic [WIDTH-1:0]     w_head_a;
    logic [TAG_WIDTH-1:0] w_head_tag;
    logic [WIDTH-1:0]     w_head_a_rev;
    logic [WIDTH-1:0]     w_sh_y_rev;
    logic [WIDTH-1:0]     w_result;

    assign w_full   = (r_count == 2'd2);
    assign w_empty  = (r_count == 2'd0);
    assign IN_READY = ~RST & ~w_full;
    assign w_push   = IN_VALID & IN_READY;
    assign w_pop    = ~w_empty & (~r_out_valid | OUT_READY);

    assign w_head_funct = r_funct[r_rptr];
    assign w_head_w     = r_w[r_rptr];
    assign w_head_a     = r_a[r_rptr];
    assign w_head_tag   = r_tag[r_rptr];

    // Left shifts run through the right shifter on bit-reversed data
    for (genvar i = 0; i < WIDTH; i++) begin : g_rev
        assign w_head_a_rev[i] = w_head_a[WIDTH-1-i];
        assign w_sh_y_rev[i]   = SH_Y[WIDTH-1-i];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_wptr <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload needs no reset: it is only observed through a valid pointer
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_funct[r_wptr] <= IN_FUNCT;
            r_w[r_wptr]     <= IN_W;
            r_a[r_wptr]     <= IN_A;
            r_tag[r_wptr]   <= IN_TAG;
        end
    end

    always_comb begin
        SH_OP = 1'b0;
        SH_W  = '0;
        SH_A  = '0;
        if (!w_empty) begin
            case (w_head_funct)
                c_sll: begin
                    SH_A = w_head_a_rev;
                    SH_W = w_head_w;
                end
                c_srl: begin
                    SH_A = w_head_a;
                    SH_W = w_head_w;
                end
                c_sra: begin
                    SH_OP = 1'b1;
                    SH_A  = w_head_a;
                    SH_W  = w_head_w;
                end
                default: begin
                    SH_A = w_head_a;
                end
            endcase
        end
    end

    always_comb begin
        w_result = SH_Y;
        case (w_head_funct)
            c_sll:   w_result = w_sh_y_rev;
            c_rsv:   w_result = w_head_a;
            default: w_result = SH_Y;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_out_valid <= 1'b0;
            r_out_y     <= '0;
            r_out_tag   <= '0;
            r_out_err   <= 1'b0;
        end else if (w_pop) begin
            r_out_valid <= 1'b1;
            r_out_y     <= w_result;
            r_out_tag   <= w_head_tag;
            r_out_err   <= (w_head_funct == c_rsv);
        end else if (OUT_READY) begin
            r_out_valid <= 1'b0;
        end
    end

    assign OUT_VALID = r_out_valid;
    assign OUT_Y     = r_out_y;
    assign OUT_TAG   = r_out_tag;
    assign OUT_ERR   = r_out_err;

endmodule
`default_nettype wire

// File: tb/tb_shift_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_issue_stage
// Function : self-checking bench for shift_issue_stage with a behavioural
//            barrel shifter on the SH_* side and a queue-based result model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_issue_stage;

    localparam int WIDTH     = 32;
    localparam int TAG_WIDTH = 4;
    localparam int NOPS      = 10000;
    localparam int MAXCYC    = 60000;

    logic                 CLK;
    logic                 RST;
    logic                 IN_VALID;
    logic                 IN_READY;
    logic [1:0]           IN_FUNCT;
    logic [4:0]           IN_W;
    logic [WIDTH-1:0]     IN_A;
    logic [TAG_WIDTH-1:0] IN_TAG;
    logic                 SH_OP;
    logic [4:0]           SH_W;
    logic [WIDTH-1:0]     SH_A;
    logic [WIDTH-1:0]     SH_Y;
    logic                 OUT_VALID;
    logic                 OUT_READY;
    logic [WIDTH-1:0]     OUT_Y;
    logic [TAG_WIDTH-1:0] OUT_TAG;
    logic                 OUT_ERR;

    shift_issue_stage #(.WIDTH(WIDTH), .TAG_WIDTH(TAG_WIDTH)) dut (
        .CLK(CLK), .RST(RST),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_FUNCT(IN_FUNCT),
        .IN_W(IN_W), .IN_A(IN_A), .IN_TAG(IN_TAG),
        .SH_OP(SH_OP), .SH_W(SH_W), .SH_A(SH_A), .SH_Y(SH_Y),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_Y(OUT_Y),
        .OUT_TAG(OUT_TAG), .OUT_ERR(OUT_ERR)
    );

    // The external right-only shifter
    assign SH_Y = SH_OP ? WIDTH'($signed(SH_A) >>> SH_W) : (SH_A >> SH_W);

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [1:0]  funct;
        logic [4:0]  w;
        logic [31:0] a;
        logic [3:0]  tag;
        logic [31:0] y;
        logic        err;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t vecs [10];
    vec_t bp   [4];
    logic [36:0] q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input vec_t v);
        IN_VALID = 1'b1;
        IN_FUNCT = v.funct;
        IN_W     = v.w;
        IN_A     = v.a;
        IN_TAG   = v.tag;
    endtask

    function automatic logic [31:0] rev(input logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = x[31-i];
        return r;
    endfunction

    // {err, tag, y} straight from the ISA meaning of each funct
    function automatic logic [36:0] model(input logic [1:0] f, input logic [4:0] w,
                                          input logic [31:0] a, input logic [3:0] t);
        logic [31:0] y;
        logic        e;
        e = 1'b0;
        case (f)
            2'b00:   y = a << w;
            2'b01:   y = a >> w;
            2'b11:   y = $unsigned($signed(a) >>> w);
            default: begin y = a; e = 1'b1; end
        endcase
        return {e, t, y};
    endfunction

    function automatic logic [36:0] outv(input vec_t v);
        return {v.err, v.tag, v.y};
    endfunction

    initial begin
        vecs[0] = '{2'b00, 5'd4,  32'h0000_00F1, 4'd1,  32'h0000_0F10, 1'b0};
        vecs[1] = '{2'b01, 5'd31, 32'h8000_0000, 4'd2,  32'h0000_0001, 1'b0};
        vecs[2] = '{2'b11, 5'd31, 32'h8000_0000, 4'd3,  32'hFFFF_FFFF, 1'b0};
        vecs[3] = '{2'b11, 5'd4,  32'h7FFF_FFF0, 4'd4,  32'h07FF_FFFF, 1'b0};
        vecs[4] = '{2'b10, 5'd7,  32'h1234_5678, 4'd5,  32'h1234_5678, 1'b1};
        vecs[5] = '{2'b01, 5'd8,  32'h1234_5678, 4'd6,  32'h0012_3456, 1'b0};
        vecs[6] = '{2'b00, 5'd0,  32'h8000_0001, 4'd7,  32'h8000_0001, 1'b0};
        vecs[7] = '{2'b11, 5'd0,  32'h8000_0001, 4'd8,  32'h8000_0001, 1'b0};
        vecs[8] = '{2'b00, 5'd1,  32'h8000_0001, 4'd9,  32'h0000_0002, 1'b0};
        vecs[9] = '{2'b00, 5'd31, 32'hFFFF_FFFF, 4'd10, 32'h8000_0000, 1'b0};

        bp[0] = '{2'b01, 5'd4, 32'hF000_0000, 4'd1, 32'h0F00_0000, 1'b0};
        bp[1] = '{2'b00, 5'd8, 32'h0000_000F, 4'd2, 32'h0000_0F00, 1'b0};
        bp[2] = '{2'b11, 5'd4, 32'h8000_0000, 4'd3, 32'hF800_0000, 1'b0};
        bp[3] = '{2'b10, 5'd3, 32'hCAFE_F00D, 4'd4, 32'hCAFE_F00D, 1'b1};

        // Reset with IN_VALID asserted
        RST = 1'b1; OUT_READY = 1'b1;
        drive(vecs[0]);
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("reset_in_ready", IN_READY, 0);
            chk("reset_out_valid", OUT_VALID, 0);
            chk("reset_out", {OUT_ERR, OUT_TAG, OUT_Y}, 0);
            chk("reset_sh", {SH_OP, SH_W, SH_A}, 0);
        end
        RST = 1'b0; IN_VALID = 1'b0;
        tick();
        chk("post_reset_in_ready", IN_READY, 1);
        chk("post_reset_out_valid", OUT_VALID, 0);

        // Streamed table: result of vector i visible two edges after its drive
        for (int i = 0; i <= 10; i++) begin
            if (i < 10) begin
                drive(vecs[i]);
                chk("stream_in_ready", IN_READY, 1);
            end else begin
                IN_VALID = 1'b0;
            end
            tick();
            if (i >= 1) begin
                chk("stream_out_valid", OUT_VALID, 1);
                chk("stream_result", {OUT_ERR, OUT_TAG, OUT_Y}, outv(vecs[i-1]));
            end
        end
        tick();
        chk("idle_out_valid", OUT_VALID, 0);
        chk("idle_out_hold", {OUT_ERR, OUT_TAG, OUT_Y}, outv(vecs[9]));

        // Back-pressure: three absorbed, the fourth waits
        OUT_READY = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(bp[k]);
            chk("bp_accept", IN_READY, 1);
            tick();
        end
        drive(bp[3]);
        chk("bp_full_in_ready", IN_READY, 0);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("bp_stall_in_ready", IN_READY, 0);
            chk("bp_stall_valid", OUT_VALID, 1);
            chk("bp_stall_hold", {OUT_ERR, OUT_TAG, OUT_Y}, outv(bp[0]));
        end
        chk("bp_sh_sll", {SH_OP, SH_W, SH_A}, {1'b0, bp[1].w, rev(bp[1].a)});
        OUT_READY = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("bp_drain_valid", OUT_VALID, 1);
            chk("bp_drain_result", {OUT_ERR, OUT_TAG, OUT_Y}, outv(bp[k]));
            if (k == 0) chk("bp_no_push_through", IN_READY, 0);
            if (k == 1) begin
                chk("bp_fourth_accept", IN_READY, 1);
                chk("bp_sh_sra", {SH_OP, SH_W, SH_A}, {1'b1, bp[2].w, bp[2].a});
            end
            tick();
            if (k == 1) IN_VALID = 1'b0;
        end
        chk("bp_drained", OUT_VALID, 0);

        // Reset with results buffered and pending
        OUT_READY = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(vecs[k]);
            tick();
        end
        IN_VALID = 1'b0;
        chk("mid_pre_valid", OUT_VALID, 1);
        chk("mid_pre_full", IN_READY, 0);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("mid_rst_valid", OUT_VALID, 0);
        chk("mid_rst_out", {OUT_ERR, OUT_TAG, OUT_Y}, 0);
        OUT_READY = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("mid_no_stale", OUT_VALID, 0);
        end
        drive(vecs[3]);
        tick();
        IN_VALID = 1'b0;
        chk("mid_new_latency", OUT_VALID, 0);
        tick();
        chk("mid_new_valid", OUT_VALID, 1);
        chk("mid_new_result", {OUT_ERR, OUT_TAG, OUT_Y}, outv(vecs[3]));
        tick();

        // Random traffic against the queue model
        begin
            int accepted = 0;
            int delivered = 0;
            int cycles = 0;
            logic hold_prev = 1'b0;
            logic [36:0] prev = '0;
            logic [36:0] exp;
            while ((accepted < NOPS || q.size() != 0 || OUT_VALID) && cycles < MAXCYC) begin
                IN_VALID  = (accepted < NOPS) && ($urandom_range(0, 3) != 0);
                IN_FUNCT  = 2'($urandom_range(0, 3));
                IN_W      = 5'($urandom);
                IN_A      = $urandom;
                IN_TAG    = 4'($urandom);
                OUT_READY = ($urandom_range(0, 3) != 0);
                @(negedge CLK);
                if (hold_prev) chk("rand_hold", {OUT_ERR, OUT_TAG, OUT_Y}, prev);
                if (OUT_VALID && OUT_READY) begin
                    if (q.size() == 0) begin
                        chk("rand_extra_result", 1, 0);
                    end else begin
                        exp = q.pop_front();
                        chk("rand_result", {OUT_ERR, OUT_TAG, OUT_Y}, exp);
                        delivered++;
                    end
                end
                if (IN_VALID && IN_READY) begin
                    q.push_back(model(IN_FUNCT, IN_W, IN_A, IN_TAG));
                    accepted++;
                end
                hold_prev = OUT_VALID && !OUT_READY;
                prev = {OUT_ERR, OUT_TAG, OUT_Y};
                tick();
                cycles++;
            end
            IN_VALID = 1'b0;
            chk("rand_budget", (cycles < MAXCYC), 1);
            chk("rand_delivered", delivered, NOPS);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
